// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives memory read port 1 and hands instructions to decode
// over a valid/ready handshake, with PC redirect and a handshake counter.
module instr_fetch_unit #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 32,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_r_adrs,
    input  logic [DATA_W-1:0] mem_data,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       fetch_count
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic              pend_q, pend_d;
    logic              if_valid_q, if_valid_d;
    logic [DATA_W-1:0] if_instr_q, if_instr_d;
    logic [31:0]       fetch_count_q, fetch_count_d;

    logic handshake;
    logic capture;
    logic issue;

    // The memory holds its output until the next read, so a new read is only
    // allowed once the pending response is captured in this same cycle.
    assign handshake  = if_valid_q && if_ready;
    assign capture    = pend_q && (!if_valid_q || if_ready);
    assign issue      = resetn && !redirect_valid && fetch_en && (!pend_q || capture);
    assign mem_r_en   = resetn && fetch_en && (redirect_valid || !pend_q || capture);
    assign mem_r_adrs = redirect_valid ? redirect_pc : pc_q;

    always_comb begin
        pc_d          = pc_q;
        pend_d        = pend_q;
        pend_pc_d     = pend_pc_q;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        fetch_count_d = handshake ? fetch_count_q + 32'd1 : fetch_count_q;

        if (redirect_valid) begin
            // Flush both the presented instruction and any in-flight response.
            if_valid_d = 1'b0;
            pend_d     = fetch_en;
            if (fetch_en) begin
                pend_pc_d = redirect_pc;
                pc_d      = redirect_pc + 1'b1;
            end else begin
                pc_d = redirect_pc;
            end
        end else begin
            if (issue) begin
                pend_d    = 1'b1;
                pend_pc_d = pc_q;
                pc_d      = pc_q + 1'b1;
            end else if (capture) begin
                pend_d = 1'b0;
            end

            if (capture) begin
                if_valid_d = 1'b1;
                if_instr_d = mem_data;
                if_pc_d    = pend_pc_q;
            end else if (handshake) begin
                if_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_q          <= ADDR_W'(RESET_PC);
            pend_q        <= 1'b0;
            pend_pc_q     <= '0;
            if_valid_q    <= 1'b0;
            if_instr_q    <= '0;
            if_pc_q       <= '0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            pend_q        <= pend_d;
            pend_pc_q     <= pend_pc_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign fetch_count = fetch_count_q;

endmodule
